// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared FSM states, status-byte bit positions and axis saturation helper
package ps2_mouse_pkg;
    typedef enum logic [1:0] {S_STATUS, S_XBYTE, S_YBYTE} state_t;
    localparam int SYNC = 3;
    localparam int XS = 4;
    localparam int YS = 5;
    localparam int XO = 6;
    localparam int YO = 7;
    localparam logic [8:0] SAT_POS = 9'h0FF;
    localparam logic [8:0] SAT_NEG = 9'h101;
    // -256 has no 8-bit magnitude, so it folds onto -255 like a negative overflow
    function automatic logic [8:0] sat_axis(input logic ovf, input logic sign, input logic [7:0] mag);
        return ovf ? (sign ? SAT_NEG : SAT_POS) : ({sign, mag} == 9'h100 ? SAT_NEG : {sign, mag});
    endfunction
endpackage

// File: rtl/ps2_timeout_counter.sv
// ps2_timeout_counter: idle-cycle counter flagging when a partial packet has stalled too long
module ps2_timeout_counter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] count;
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (enable) count <= count + 16'd1;
    end
    assign expired = enable && count == TIMEOUT_CYCLES - 16'd1;
endmodule

// File: rtl/ps2_packet_assembler.sv
// ps2_packet_assembler: collects 3-byte PS/2 mouse packets into saturated 9-bit axis outputs
module ps2_packet_assembler
    import ps2_mouse_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic [8:0] x_axis,
    output logic [8:0] y_axis,
    output logic [2:0] buttons,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       pkt_valid,
    output logic       sync_err
);
    state_t     state;
    logic [7:4] flags_q;
    logic [2:0] btn_q;
    logic [7:0] xbyte_q;
    logic       expired;
    ps2_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == S_STATUS || rx_valid || rx_error || expired),
        .enable (state != S_STATUS),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_STATUS;
            flags_q   <= '0;
            btn_q     <= '0;
            xbyte_q   <= '0;
            x_axis    <= '0;
            y_axis    <= '0;
            buttons   <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (rx_error) begin
                state    <= S_STATUS;
                sync_err <= 1'b1;
            end else if (rx_valid) begin
                case (state)
                    S_STATUS: begin
                        if (rx_data[SYNC]) begin
                            flags_q <= rx_data[7:4];
                            btn_q   <= rx_data[2:0];
                            state   <= S_XBYTE;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    S_XBYTE: begin
                        xbyte_q <= rx_data;
                        state   <= S_YBYTE;
                    end
                    default: begin
                        x_axis    <= sat_axis(flags_q[XO], flags_q[XS], xbyte_q);
                        y_axis    <= sat_axis(flags_q[YO], flags_q[YS], rx_data);
                        buttons   <= btn_q;
                        x_ovf     <= flags_q[XO];
                        y_ovf     <= flags_q[YO];
                        pkt_valid <= 1'b1;
                        state     <= S_STATUS;
                    end
                endcase
            end else if (expired) begin
                state    <= S_STATUS;
                sync_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_packet_assembler.sv
// tb_ps2_packet_assembler: directed packets checked every cycle against a byte-list model plus literal pins
module tb_ps2_packet_assembler;
    localparam int T = 20;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [8:0] x_axis, y_axis;
    logic [2:0] buttons;
    logic       x_ovf, y_ovf, pkt_valid, sync_err;
    int checks = 0;
    int failures = 0;
    int m_n = 0;
    int m_idle = 0;
    logic [7:0] m_status = 8'h00;
    logic [7:0] m_x = 8'h00;
    logic [8:0] e_x = '0, e_y = '0;
    logic [2:0] e_btn = '0;
    logic       e_xo = 0, e_yo = 0, e_pv = 0, e_se = 0;

    ps2_packet_assembler #(.TIMEOUT_CYCLES(16'(T))) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .x_axis(x_axis), .y_axis(y_axis), .buttons(buttons), .x_ovf(x_ovf), .y_ovf(y_ovf),
        .pkt_valid(pkt_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // movement as a signed integer, then saturated to the +/-255 range
    function automatic logic [8:0] axis(input logic ovf, input logic sign, input logic [7:0] b);
        int v;
        logic [31:0] u;
        v = sign ? int'(b) - 256 : int'(b);
        if (ovf) v = sign ? -255 : 255;
        if (v < -255) v = -255;
        u = v;
        return u[8:0];
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic e, input logic [7:0] d);
        @(negedge clk);
        rst = r; rx_valid = v; rx_error = e; rx_data = d;
        e_pv = 0; e_se = 0;
        if (r) begin
            m_n = 0; m_idle = 0;
            e_x = '0; e_y = '0; e_btn = '0; e_xo = 0; e_yo = 0;
        end else if (e) begin
            e_se = 1; m_n = 0; m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            if (m_n == 0) begin
                if (d[3]) begin m_status = d; m_n = 1; end
                else e_se = 1;
            end else if (m_n == 1) begin
                m_x = d; m_n = 2;
            end else begin
                e_x = axis(m_status[6], m_status[4], m_x);
                e_y = axis(m_status[7], m_status[5], d);
                e_btn = m_status[2:0];
                e_xo = m_status[6];
                e_yo = m_status[7];
                e_pv = 1;
                m_n = 0;
            end
        end else if (m_n > 0) begin
            m_idle++;
            if (m_idle == T) begin e_se = 1; m_n = 0; m_idle = 0; end
        end
        @(posedge clk);
        #1;
        chk("x_axis", x_axis, e_x);
        chk("y_axis", y_axis, e_y);
        chk("buttons", 9'(buttons), 9'(e_btn));
        chk("ovf", 9'({x_ovf, y_ovf}), 9'({e_xo, e_yo}));
        chk("pkt_valid", 9'(pkt_valid), 9'(e_pv));
        chk("sync_err", 9'(sync_err), 9'(e_se));
        chk("exclusive", 9'(pkt_valid & sync_err), 9'd0);
    endtask

    task automatic byte_in(input logic [7:0] d);
        step(0, 1, 0, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
    endtask

    task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        byte_in(a); idle(1); byte_in(b); byte_in(c);
    endtask

    initial begin
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h5A);
        chk("rst_x", x_axis, 9'h000);
        chk("rst_flags", 9'({pkt_valid, sync_err, x_ovf, y_ovf, buttons}), 9'h000);

        pkt(8'h09, 8'h20, 8'h10);
        chk("nom_pv", 9'(pkt_valid), 9'd1);
        chk("nom_x", x_axis, 9'h020);
        chk("nom_y", y_axis, 9'h010);
        chk("nom_btn", 9'(buttons), 9'h001);
        chk("model_nom_x", e_x, 9'h020);
        idle(2);
        chk("hold_x", x_axis, 9'h020);

        pkt(8'h38, 8'h00, 8'hF0);
        chk("clamp_x", x_axis, 9'h101);
        chk("clamp_y", y_axis, 9'h1F0);
        chk("model_clamp_x", e_x, 9'h101);

        pkt(8'h58, 8'h05, 8'h05);
        chk("ovf_x", x_axis, 9'h101);
        chk("ovf_xo", 9'(x_ovf), 9'd1);
        chk("ovf_y", y_axis, 9'h005);
        chk("ovf_yo", 9'(y_ovf), 9'd0);

        pkt(8'h48, 8'h80, 8'hFF);
        chk("posovf_x", x_axis, 9'h0FF);
        chk("posovf_y", y_axis, 9'h0FF);

        byte_in(8'h00);
        chk("resync_se", 9'(sync_err), 9'd1);
        chk("resync_pv", 9'(pkt_valid), 9'd0);
        pkt(8'h08, 8'h01, 8'h02);
        chk("resync_x", x_axis, 9'h001);
        chk("resync_y", y_axis, 9'h002);

        byte_in(8'h08); byte_in(8'h05);
        idle(T - 1);
        chk("tmo_early", 9'(sync_err), 9'd0);
        idle(1);
        chk("tmo_se", 9'(sync_err), 9'd1);
        pkt(8'h08, 8'h03, 8'h04);
        chk("tmo_x", x_axis, 9'h003);
        chk("tmo_y", y_axis, 9'h004);

        byte_in(8'h08);
        idle(T - 1);
        byte_in(8'h07);
        chk("edge_se", 9'(sync_err), 9'd0);
        byte_in(8'h09);
        chk("edge_pv", 9'(pkt_valid), 9'd1);
        chk("edge_x", x_axis, 9'h007);

        byte_in(8'h08); byte_in(8'h11);
        step(0, 1, 1, 8'h22);
        chk("err_se", 9'(sync_err), 9'd1);
        chk("err_pv", 9'(pkt_valid), 9'd0);
        chk("err_x", x_axis, 9'h007);
        step(0, 0, 1, 8'h00);
        chk("err_idle_se", 9'(sync_err), 9'd1);

        byte_in(8'h08); byte_in(8'h05);
        step(1, 0, 0, 8'h00);
        chk("rst_mid_se", 9'(sync_err), 9'd0);
        chk("rst_mid_x", x_axis, 9'h000);
        pkt(8'h09, 8'h01, 8'h02);
        chk("post_rst_x", x_axis, 9'h001);
        chk("post_rst_btn", 9'(buttons), 9'h001);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_packet_assembler.md
PS2_PACKET_ASSEMBLER -- requirements
Module: ps2_packet_assembler

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16'd50000, idle cycles after which a partial packet is discarded.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: rx_data  input  8  byte from PS/2 receiver.
REQ-005 SHALL have port: rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-006 SHALL have port: rx_error  input  1  one-cycle strobe, receiver parity/frame error.
REQ-007 SHALL have port: x_axis  output  9  X movement, two's complement {sign, byte}.
REQ-008 SHALL have port: y_axis  output  9  Y movement, two's complement {sign, byte}.
REQ-009 SHALL have port: buttons  output  3  {middle, right, left} from status byte bits [2:0].
REQ-010 SHALL have port: x_ovf / y_ovf  output  1 each  status bits 6 / 7 of last packet.
REQ-011 SHALL have port: pkt_valid  output  1  one-cycle pulse, new packet on outputs.
REQ-012 SHALL have port: sync_err  output  1  one-cycle pulse, packet discarded (bad sync, rx_error, timeout).

Function
REQ-013 SHALL implement FSM with states S_STATUS, S_XBYTE, S_YBYTE.
- S_STATUS + rx_valid: rx_data[3]=1 -> capture status, go S_XBYTE; else pulse sync_err, stay.
- S_XBYTE + rx_valid: capture X byte, go S_YBYTE.
- S_YBYTE + rx_valid: capture Y byte, go S_STATUS, publish packet.
REQ-014 SHALL publish at the clock edge following acceptance of the Y byte: outputs updated and pkt_valid=1 in that same cycle (latency 1 cycle from Y-byte rx_valid).
REQ-015 SHALL hold x_axis, y_axis, buttons, x_ovf, y_ovf stable between publishes.
REQ-016 SHALL form raw X as {status[4], xbyte} and raw Y as {status[5], ybyte}.
REQ-017 SHALL saturate on overflow: ovf=1 and sign=0 -> 9'h0FF; ovf=1 and sign=1 -> 9'h101.
REQ-018 SHALL clamp raw 9'h100 (-256) to 9'h101 (-255) so the downstream magnitude stage never sees a non-representable 8-bit magnitude.
REQ-019 SHALL count idle cycles in S_XBYTE/S_YBYTE. The counter clears on every accepted byte. When the count reaches TIMEOUT_CYCLES-1, the FSM returns to S_STATUS and pulses sync_err. The counter is held at 0 in S_STATUS.
REQ-020 SHALL give rx_error priority: in any state it discards the partial packet, returns to S_STATUS and pulses sync_err, even if rx_valid is high in the same cycle.
REQ-021 SHALL give rx_valid precedence over timeout in the same cycle: the byte is accepted and no sync_err is raised.
REQ-022 SHALL never assert pkt_valid and sync_err in the same cycle.

Reset
REQ-023 SHALL on rst=1 at a clock edge set state=S_STATUS, timeout counter=0, x_axis=0, y_axis=0, buttons=0, x_ovf=0, y_ovf=0, pkt_valid=0, sync_err=0.
REQ-024 SHALL on reset mid-packet drop the partial packet without a sync_err pulse; the first byte after reset is treated as a status byte.

Structure
REQ-025 SHALL place the FSM state typedef, the status-bit position constants (SYNC=3, XS=4, YS=5, XO=6, YO=7) and the saturation constants 9'h0FF / 9'h101 in shared package ps2_mouse_pkg.
REQ-026 SHALL instantiate a single sub-module ps2_timeout_counter, parameterised by TIMEOUT_CYCLES, with inputs clear/enable and output expired.

Verification
REQ-027 SHALL cover nominal packet: bytes 0x09, 0x20, 0x10 -> next cycle pkt_valid=1, x_axis=9'h020, y_axis=9'h010, buttons=3'b001.
REQ-028 SHALL cover negative values and clamp: bytes 0x38, 0x00, 0xF0 -> x_axis=9'h101 (clamped from 9'h100), y_axis=9'h1F0.
REQ-029 SHALL cover overflow: bytes 0x58, 0x05, 0x05 -> x_axis=9'h101, x_ovf=1, y_axis=9'h005, y_ovf=0.
REQ-030 SHALL cover resync: byte 0x00 while in S_STATUS -> sync_err pulse, no pkt_valid; then 0x08, 0x01, 0x02 -> x_axis=9'h001, y_axis=9'h002.
REQ-031 SHALL cover timeout: 0x08, 0x05, then TIMEOUT_CYCLES idle cycles -> sync_err pulse; then 0x08, 0x03, 0x04 -> x_axis=9'h003.
REQ-032 SHALL cover error priority: rx_error and rx_valid together in S_YBYTE -> sync_err=1, pkt_valid stays 0, outputs unchanged.
